alu_result_stage: RTL

Output stage of the 16-bit ALU datapath. It takes the parallel results of the bitwise functional units (AND, OR, XOR, NOT), picks one by opcode, and derives zero/negative flags. It buffers {result, flags} in a 2-entry FIFO behind a valid/ready handshake, so the MCU writeback path can stall without losing ALU results. It also keeps a sticky-zero status bit and a delivered-result counter for the MCU status register.

---
 rtl/alu_pkg.sv | 18 +
 rtl/result_fifo2.sv | 57 +++++
 rtl/alu_result_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: width, result-select opcodes and the
// buffered result entry layout.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 16;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      logic                 z;
      logic                 n;
   } alu_entry_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO with a registered head slot and one tail slot behind it.
module result_fifo2 #(
   parameter int unsigned W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   logic [1:0]   count;
   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic         push_ok;
   logic         pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = head_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // With one entry and push+pop together, the incoming entry lands straight in the head slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (empty) head_q <= din;
               else       tail_q <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: opcode result select, zero/negative flags, 2-deep
// buffering toward writeback, plus sticky-zero and delivered-result count.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] AND_R,
   input  logic [WIDTH-1:0] OR_R,
   input  logic [WIDTH-1:0] XOR_R,
   input  logic [WIDTH-1:0] NOT_R,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT,
   output logic             FLAG_Z,
   output logic             FLAG_N,
   output logic             STICKY_Z,
   output logic [CNT_W-1:0] CNT,
   input  logic             CLR
);

   localparam int unsigned ENTRY_W = WIDTH + 2;

   logic [WIDTH-1:0]   sel;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               sticky_q;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      sel = '0;
      case (OP)
         OP_AND:  sel = AND_R;
         OP_OR:   sel = OR_R;
         OP_XOR:  sel = XOR_R;
         OP_NOT:  sel = NOT_R;
         default: sel = '0;
      endcase
   end

   assign wr_entry  = {sel, (sel == '0), sel[WIDTH-1]};
   assign IN_READY  = !RST && !full;
   assign OUT_VALID = !empty;
   assign push      = IN_VALID && IN_READY;
   assign pop       = OUT_VALID && OUT_READY;

   result_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign OUT    = head[ENTRY_W-1:2];
   assign FLAG_Z = head[1];
   assign FLAG_N = head[0];

   // A pop coinciding with CLR is counted after the clear.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else if (CLR) begin
         cnt_q    <= pop ? CNT_W'(1) : '0;
         sticky_q <= pop && FLAG_Z;
      end else if (pop) begin
         cnt_q    <= cnt_q + CNT_W'(1);
         sticky_q <= sticky_q || FLAG_Z;
      end
   end

   assign CNT      = cnt_q;
   assign STICKY_Z = sticky_q;

endmodule
